// File: rtl/ram_pkg.sv
// Shared constants for the 256x64 ram request path: widths, controller
// state encodings and the {cen, wen} strobe pairs driven to the ram.
package ram_pkg;

  localparam int AW   = 8;
  localparam int DW   = 64;
  localparam int LENW = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WRITE = 2'd1;
  localparam state_t ST_READ  = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

  // {cen, wen}
  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b10;
  localparam logic [1:0] CMD_WR  = 2'b11;

endpackage

// File: rtl/ram_rsp_fifo.sv
// Read-response FIFO: holds {last, data} beats captured from the ram until
// the core accepts them. Head entry is presented directly on dout.
module ram_rsp_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_P = PW'(DEPTH - 1);
  localparam logic [PW-1:0] P_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] C_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_s, do_pop_s;

  assign full  = (count_q == FULL_C);
  assign empty = (count_q == {CW{1'b0}});
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; a simultaneous push and pop leaves count unchanged.
  always_comb begin
    do_push_s = push & ~full;
    do_pop_s  = pop & ~empty;
    if (do_push_s) begin
      wr_ptr_d = (wr_ptr_q == LAST_P) ? {PW{1'b0}} : wr_ptr_q + P_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = (rd_ptr_q == LAST_P) ? {PW{1'b0}} : rd_ptr_q + P_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + C_ONE;
      2'b01:   count_d = count_q - C_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers; reset clears contents so the head reads zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= din;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst request controller for the single-port ram: sequences registered
// cen/wen/s_addr/s_din strobes and returns read beats through a credit-guarded FIFO.
module ram_burst_ctrl
  import ram_pkg::*;
#(
  parameter int AW     = ram_pkg::AW,
  parameter int DW     = ram_pkg::DW,
  parameter int LENW   = ram_pkg::LENW,
  parameter int RD_LAT = 1,
  parameter int FDEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [AW-1:0]   req_addr,
  input  logic [LENW-1:0] req_len,
  input  logic            wd_valid,
  output logic            wd_ready,
  input  logic [DW-1:0]   wd_data,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [DW-1:0]   rd_data,
  output logic            rd_last,
  output logic            busy,
  output logic            cen,
  output logic            wen,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_din,
  input  logic [DW-1:0]   s_dout
);

  localparam int CW = $clog2(FDEPTH + 1);
  localparam logic [AW-1:0]   A_ONE    = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [LENW-1:0] L_ONE    = {{(LENW-1){1'b0}}, 1'b1};
  localparam logic [CW:0]     CREDIT_C = (CW + 1)'(FDEPTH);

  state_t            state_q, state_d;
  logic [AW-1:0]     cur_q, cur_d, s_addr_q, s_addr_d;
  logic [LENW-1:0]   len_q, len_d, beat_q, beat_d;
  logic [DW-1:0]     s_din_q, s_din_d;
  logic              cen_q, cen_d, wen_q, wen_d, iss_last_q, iss_last_d;
  logic [RD_LAT-1:0] tag_q, tag_d, tlast_q, tlast_d;
  logic [CW-1:0]     infl_q, infl_d, fifo_count_s;
  logic              fifo_full_s, fifo_empty_s, credit_ok_s, issue_s, cap_s, pop_s;
  logic [DW:0]       fifo_dout_s;

  // Reads already strobed or in the ram pipeline hold a FIFO slot, so a capture can never overflow.
  assign credit_ok_s = ~fifo_full_s &
                       (({1'b0, fifo_count_s} + {1'b0, infl_q}) < CREDIT_C);
  assign cap_s = tag_q[RD_LAT-1];
  assign pop_s = ~fifo_empty_s & rd_ready;

  // Burst sequencing and strobe generation.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    len_d      = len_q;
    beat_d     = beat_q;
    s_addr_d   = s_addr_q;
    s_din_d    = s_din_q;
    iss_last_d = 1'b0;
    issue_s    = 1'b0;
    {cen_d, wen_d} = CMD_NOP;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          cur_d   = req_addr;
          len_d   = req_len;
          beat_d  = {LENW{1'b0}};
          state_d = req_write ? ST_WRITE : ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (wd_valid) begin
          {cen_d, wen_d} = CMD_WR;
          s_addr_d = cur_q;
          s_din_d  = wd_data;
          cur_d    = cur_q + A_ONE;
          if (beat_q == len_q) begin
            state_d = ST_IDLE;
          end else begin
            beat_d = beat_q + L_ONE;
          end
        end else begin
          {cen_d, wen_d} = CMD_NOP;
        end
      end
      ST_READ: begin
        if (credit_ok_s) begin
          {cen_d, wen_d} = CMD_RD;
          issue_s    = 1'b1;
          s_addr_d   = cur_q;
          cur_d      = cur_q + A_ONE;
          iss_last_d = (beat_q == len_q);
          if (beat_q == len_q) begin
            state_d = ST_DRAIN;
          end else begin
            beat_d = beat_q + L_ONE;
          end
        end else begin
          {cen_d, wen_d} = CMD_NOP;
        end
      end
      ST_DRAIN: begin
        if ((infl_q == {CW{1'b0}}) && fifo_empty_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read-latency tag pipeline and in-flight accounting.
  always_comb begin
    tag_d      = tag_q;
    tlast_d    = tlast_q;
    tag_d[0]   = cen_q & ~wen_q;
    tlast_d[0] = iss_last_q;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_d[i]   = tag_q[i-1];
      tlast_d[i] = tlast_q[i-1];
    end
    infl_d = infl_q + {{(CW-1){1'b0}}, issue_s} - {{(CW-1){1'b0}}, cap_s};
  end

  // Controller registers; reset drops the ram strobes without waiting for a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cur_q      <= {AW{1'b0}};
      len_q      <= {LENW{1'b0}};
      beat_q     <= {LENW{1'b0}};
      cen_q      <= 1'b0;
      wen_q      <= 1'b0;
      s_addr_q   <= {AW{1'b0}};
      s_din_q    <= {DW{1'b0}};
      iss_last_q <= 1'b0;
      tag_q      <= {RD_LAT{1'b0}};
      tlast_q    <= {RD_LAT{1'b0}};
      infl_q     <= {CW{1'b0}};
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      cen_q      <= cen_d;
      wen_q      <= wen_d;
      s_addr_q   <= s_addr_d;
      s_din_q    <= s_din_d;
      iss_last_q <= iss_last_d;
      tag_q      <= tag_d;
      tlast_q    <= tlast_d;
      infl_q     <= infl_d;
    end
  end

  ram_rsp_fifo #(
    .W     (DW + 1),
    .DEPTH (FDEPTH),
    .CW    (CW)
  ) u_rsp_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (cap_s),
    .din     ({tlast_q[RD_LAT-1], s_dout}),
    .pop     (pop_s),
    .dout    (fifo_dout_s),
    .count   (fifo_count_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign wd_ready  = (state_q == ST_WRITE);
  assign rd_valid  = ~fifo_empty_s;
  assign rd_data   = fifo_dout_s[DW-1:0];
  assign rd_last   = fifo_dout_s[DW];
  assign cen       = cen_q;
  assign wen       = wen_q;
  assign s_addr    = s_addr_q;
  assign s_din     = s_din_q;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed + randomized bench for ram_burst_ctrl with a behavioural ram and
// a queue-based reference of expected strobes and read responses.
module tb_ram_burst_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [7:0]  req_addr = 8'd0;
  logic [3:0]  req_len = 4'd0;
  logic        wd_valid = 1'b0, wd_ready;
  logic [63:0] wd_data = 64'd0;
  logic        rd_valid, rd_ready = 1'b1, rd_last, busy, cen, wen;
  logic [63:0] rd_data, s_din, s_dout;
  logic [7:0]  s_addr;

  ram_burst_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .cen(cen), .wen(wen), .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout)
  );

  always #5 clk = ~clk;

  // Behavioural ram, one-edge read latency.
  logic [63:0] ram_mem [256];
  always @(posedge clk) begin
    if (cen) begin
      if (wen) ram_mem[s_addr] <= s_din;
      else     s_dout <= ram_mem[s_addr];
    end
  end

  logic [63:0] ref_mem [256];
  logic [71:0] exp_wr [$];   // {addr, data}
  logic [64:0] exp_rd [$];   // {last, data}
  logic [7:0]  exp_iss [$];
  logic [63:0] wbuf [16];
  int          checks = 0, fails = 0, wr_left = 0, n_iss = 0;
  logic        req_acc = 1'b0, hold_v = 1'b0, hold_l;
  logic [63:0] hold_d;
  logic [7:0]  wr_cur = 8'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: record handshakes before the edge, check strobes after it.
  task automatic tick();
    logic [71:0] ew;
    logic [64:0] er;
    logic [7:0]  a;
    if (req_valid && req_ready) begin
      req_acc = 1'b1;
      n_iss   = 0;
      if (req_write) begin
        wr_cur  = req_addr;
        wr_left = int'(req_len) + 1;
      end else begin
        for (int i = 0; i <= int'(req_len); i++) begin
          a = req_addr + 8'(i);
          exp_iss.push_back(a);
          exp_rd.push_back({(i == int'(req_len)), ref_mem[a]});
        end
      end
    end
    if (wd_valid && wd_ready) begin
      exp_wr.push_back({wr_cur, wd_data});
      ref_mem[wr_cur] = wd_data;
      wr_cur  = wr_cur + 8'd1;
      wr_left--;
    end
    if (rd_valid) begin
      if (hold_v) begin
        chk("rd_hold_data", rd_data, hold_d);
        chk("rd_hold_last", {63'd0, rd_last}, {63'd0, hold_l});
      end
      if (rd_ready) begin
        hold_v = 1'b0;
        if (exp_rd.size() == 0) chk("rd_extra", {63'd0, rd_valid}, 64'd0);
        else begin
          er = exp_rd.pop_front();
          chk("rd_data", rd_data, er[63:0]);
          chk("rd_last", {63'd0, rd_last}, {63'd0, er[64]});
        end
      end else begin
        hold_v = 1'b1;
        hold_d = rd_data;
        hold_l = rd_last;
      end
    end
    @(posedge clk);
    #1;
    if (cen && wen) begin
      if (exp_wr.size() == 0) chk("wr_extra", {63'd0, cen}, 64'd0);
      else begin
        ew = exp_wr.pop_front();
        chk("wr_addr", {56'd0, s_addr}, {56'd0, ew[71:64]});
        chk("wr_data", s_din, ew[63:0]);
      end
    end
    if (cen && !wen) begin
      n_iss++;
      if (exp_iss.size() == 0) chk("rd_iss_extra", {63'd0, cen}, 64'd0);
      else chk("rd_iss_addr", {56'd0, s_addr}, {56'd0, exp_iss.pop_front()});
    end
  endtask

  task automatic send_req(input logic wr, input logic [7:0] addr, input logic [3:0] len);
    req_write = wr; req_addr = addr; req_len = len; req_valid = 1'b1; req_acc = 1'b0;
    for (int t = 0; t < 50 && !req_acc; t++) tick();
    req_valid = 1'b0;
    chk("req_accept", {63'd0, req_acc}, 64'd1);
  endtask

  // mode: 0 always valid, 1 pattern 1,0,0, 2 random
  task automatic do_write(input logic [7:0] addr, input int len, input int mode, input bit poke);
    send_req(1'b1, addr, 4'(len));
    for (int t = 0; t < 300 && wr_left > 0; t++) begin
      case (mode)
        0:       wd_valid = 1'b1;
        1:       wd_valid = (t % 3 == 0);
        default: wd_valid = 1'($urandom_range(0, 1));
      endcase
      wd_data = wbuf[len + 1 - wr_left];
      if (poke && t == 1) begin
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h33; req_len = 4'd2;
        chk("ign_req_ready", {63'd0, req_ready}, 64'd0);
      end else begin
        req_valid = 1'b0;
      end
      tick();
    end
    wd_valid = 1'b0; req_valid = 1'b0;
    chk("wr_beats_done", 64'(wr_left), 64'd0);
    tick(); tick();
    chk("wr_strobes_all", 64'(exp_wr.size()), 64'd0);
    chk("wr_idle", {63'd0, busy}, 64'd0);
  endtask

  // mode: 0 always ready, 1 random ready, 2 hold off 10 cycles then ready
  task automatic do_read(input logic [7:0] addr, input int len, input int mode, input bit lat);
    rd_ready = 1'b1;
    if (mode == 2) rd_ready = 1'b0;
    send_req(1'b0, addr, 4'(len));
    if (lat) begin
      tick(); tick();
      chk("lat_edge2_valid", {63'd0, rd_valid}, 64'd0);
      tick();
      chk("lat_edge3_valid", {63'd0, rd_valid}, 64'd1);
    end
    if (mode == 2) begin
      for (int t = 0; t < 10; t++) tick();
      chk("bp_issue_count", 64'(n_iss), 64'd4);
      chk("bp_valid", {63'd0, rd_valid}, 64'd1);
    end
    for (int t = 0; t < 500 && exp_rd.size() > 0; t++) begin
      rd_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
    rd_ready = 1'b1;
    chk("rd_all_beats", 64'(exp_rd.size()), 64'd0);
    chk("rd_all_issued", 64'(exp_iss.size()), 64'd0);
    tick(); tick();
    chk("rd_busy_done", {63'd0, busy}, 64'd0);
    chk("rd_req_ready", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 64'd0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_wd_ready", {63'd0, wd_ready}, 64'd0);
    chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_rd_last", {63'd0, rd_last}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_cen", {63'd0, cen}, 64'd0);
    chk("rst_wen", {63'd0, wen}, 64'd0);
    chk("rst_s_addr", {56'd0, s_addr}, 64'd0);
    chk("rst_s_din", s_din, 64'd0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    tick();

    // single write then single-beat read with latency check
    wbuf[0] = 64'hABCD_EFFF;
    do_write(8'd5, 0, 0, 1'b0);
    do_read(8'd5, 0, 0, 1'b1);

    // address wrap
    for (int i = 0; i < 4; i++) wbuf[i] = 64'(i + 1);
    do_write(8'hFE, 3, 0, 1'b0);
    do_read(8'hFE, 3, 0, 1'b0);

    // write gaps
    for (int i = 0; i < 4; i++) wbuf[i] = 64'h1000 + 64'(i);
    do_write(8'h40, 3, 1, 1'b0);
    do_read(8'h40, 3, 1, 1'b0);

    // request during a write burst is ignored
    for (int i = 0; i < 4; i++) wbuf[i] = {$urandom(), $urandom()};
    do_write(8'h60, 3, 0, 1'b1);
    do_read(8'h60, 3, 0, 1'b0);

    // read backpressure over a full 16-beat burst
    for (int i = 0; i < 16; i++) wbuf[i] = {$urandom(), $urandom()};
    do_write(8'h00, 15, 2, 1'b0);
    do_read(8'h00, 15, 2, 1'b0);

    // reset in the middle of a read burst
    rd_ready = 1'b0;
    send_req(1'b0, 8'h00, 4'd7);
    for (int t = 0; t < 20 && n_iss < 2; t++) tick();
    chk("rstmid_issued", 64'(n_iss), 64'd2);
    reset_n = 1'b0;
    #1;
    chk("rstmid_cen", {63'd0, cen}, 64'd0);
    chk("rstmid_wen", {63'd0, wen}, 64'd0);
    exp_rd.delete(); exp_iss.delete(); exp_wr.delete(); hold_v = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    rd_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk("rstmid_rd_valid", {63'd0, rd_valid}, 64'd0);
    end
    chk("rstmid_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rstmid_busy", {63'd0, busy}, 64'd0);

    // randomized write/read-back bursts
    for (int k = 0; k < 8; k++) begin
      logic [7:0] ra;
      int         rl;
      ra = 8'($urandom());
      rl = int'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) wbuf[i] = {$urandom(), $urandom()};
      do_write(ra, rl, 2, 1'b0);
      do_read(ra, rl, 1, 1'b0);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
